// File: rtl/addsub_arbiter.sv
// addsub_arbiter: one registered N-bit add/sub unit shared by two requester
// lanes. Round-robin grant, valid/ready on both sides, one result per cycle.
module addsub_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         IN_valid0,
    input  logic         IN_sub0,
    input  logic [N-1:0] IN_dataA0,
    input  logic [N-1:0] IN_dataB0,
    output logic         OUT_ready0,
    input  logic         IN_valid1,
    input  logic         IN_sub1,
    input  logic [N-1:0] IN_dataA1,
    input  logic [N-1:0] IN_dataB1,
    output logic         OUT_ready1,
    output logic         OUT_valid,
    output logic [N-1:0] OUT_data,
    output logic         OUT_carry,
    output logic         OUT_id,
    input  logic         IN_outReady
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t   state;
    logic         prio;
    logic [N-1:0] data_q;
    logic         carry_q;
    logic         id_q;

    logic         slot_free;
    logic         win0;
    logic         win1;
    logic         accept;
    logic         sel_sub;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;
    logic [N-1:0] opnd_b;
    logic [N:0]   sum;

    // Grant: a lone valid lane wins, a contested cycle goes to the favoured lane;
    // readies are gated by reset so nothing is accepted while rst_n is low.
    always_comb begin
        slot_free  = (state == EMPTY) | IN_outReady;
        win0       = IN_valid0 & (~IN_valid1 | ~prio);
        win1       = IN_valid1 & (~IN_valid0 | prio);
        OUT_ready0 = rst_n & slot_free & win0;
        OUT_ready1 = rst_n & slot_free & win1;
        accept     = OUT_ready0 | OUT_ready1;
    end

    // Shared datapath: mux the winning lane, subtract as A + ~B + 1 in N+1 bits.
    always_comb begin
        sel_a   = win1 ? IN_dataA1 : IN_dataA0;
        sel_b   = win1 ? IN_dataB1 : IN_dataB0;
        sel_sub = win1 ? IN_sub1   : IN_sub0;
        opnd_b  = sel_sub ? ~sel_b : sel_b;
        sum     = {1'b0, sel_a} + {1'b0, opnd_b} + {{N{1'b0}}, sel_sub};
    end

    // Output register FSM plus round-robin pointer; the pointer only moves on an
    // accepted grant and always points away from the lane just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            prio    <= 1'b0;
            data_q  <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state   <= FULL;
                        data_q  <= sum[N-1:0];
                        carry_q <= sum[N] ^ sel_sub;
                        id_q    <= win1;
                        prio    <= ~win1;
                    end
                end
                FULL: begin
                    if (accept) begin
                        state   <= FULL;
                        data_q  <= sum[N-1:0];
                        carry_q <= sum[N] ^ sel_sub;
                        id_q    <= win1;
                        prio    <= ~win1;
                    end else if (IN_outReady) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign OUT_valid = (state == FULL);
    assign OUT_data  = data_q;
    assign OUT_carry = carry_q;
    assign OUT_id    = id_q;

endmodule
